// File: rtl/charge_session_ctrl_pkg.sv
// Shared types and widths for the charge session sequencer.
// Credit helpers live here so Timer/display code can reuse them.
package charge_session_ctrl_pkg;

  localparam int CREDIT_W = 5;
  localparam int TIME_W   = 14;
  localparam int COIN_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    INPUT,
    LOAD,
    CHARGING,
    DONE
  } state_t;

  typedef struct packed {
    logic [CREDIT_W-1:0] credit;
    logic [CREDIT_W-1:0] excess;
  } credit_add_t;

  // Add a coin with one extra bit of headroom, then clamp to cap.
  function automatic credit_add_t credit_add(
    input logic [CREDIT_W-1:0] cur,
    input logic [COIN_W-1:0]   coin,
    input logic [CREDIT_W:0]   cap
  );
    logic [CREDIT_W:0] sum;
    credit_add_t       r;
    sum = {1'b0, cur} + (CREDIT_W+1)'(coin);
    if (sum > cap) begin
      r.credit = cap[CREDIT_W-1:0];
      r.excess = CREDIT_W'(sum - cap);
    end else begin
      r.credit = sum[CREDIT_W-1:0];
      r.excess = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/charge_session_ctrl_ms_down_counter.sv
// Millisecond down counter with load, enable and zero flag.
// Holds at zero once it gets there.
module ms_down_counter #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Reload has priority over counting; stop at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/charge_session_ctrl.sv
// Coin charger session sequencer: credit, Timer load/start,
// ack watchdog, cancel and refund handling.
module charge_session_ctrl
  import charge_session_ctrl_pkg::*;
#(
  parameter int MAX_CREDIT   = 20,
  parameter int SEC_PER_UNIT = 60,
  parameter int IDLE_TO_MS   = 10000,
  parameter int DONE_HOLD_MS = 2000,
  parameter int ACK_TO_MS    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [COIN_W-1:0]   coin_val,
  input  logic                start_btn,
  input  logic                cancel_btn,
  input  logic                tmr_timing,
  input  logic [TIME_W-1:0]   tmr_cnt,
  output logic                tmr_load,
  output logic [TIME_W-1:0]   tmr_load_val,
  output logic                tmr_start,
  output logic [CREDIT_W-1:0] credit,
  output logic [TIME_W-1:0]   remain_sec,
  output logic                charging,
  output logic                refund,
  output logic [CREDIT_W-1:0] refund_amt,
  output logic                fault
);

  localparam logic [CREDIT_W:0] CAP =
    (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [TIME_W-1:0] SPU =
    TIME_W'(SEC_PER_UNIT);
  localparam logic [TIME_W-1:0] IDLE_RLD =
    TIME_W'(IDLE_TO_MS - 1);
  localparam logic [TIME_W-1:0] DONE_RLD =
    TIME_W'(DONE_HOLD_MS - 1);
  localparam int ACK_W = $clog2(ACK_TO_MS + 1);
  localparam logic [ACK_W-1:0] ACK_LAST =
    ACK_W'(ACK_TO_MS - 1);

  state_t            state;
  logic [ACK_W-1:0]  ack_cnt;
  logic              acked;
  credit_add_t       add;
  credit_add_t       first;
  logic              tmo_load;
  logic [TIME_W-1:0] tmo_val;
  logic              tmo_en;
  logic              tmo_zero;
  logic              chg_end;

  assign chg_end = acked && !tmr_timing;

  // Credit arithmetic and shared timeout reload selection.
  always_comb begin
    add      = credit_add(credit, coin_val, CAP);
    first    = credit_add('0, coin_val, CAP);
    tmo_load = 1'b0;
    tmo_val  = IDLE_RLD;
    unique case (state)
      IDLE: tmo_load = coin_valid;
      INPUT: tmo_load = coin_valid || start_btn;
      CHARGING: begin
        if (cancel_btn || chg_end) begin
          tmo_load = 1'b1;
          tmo_val  = DONE_RLD;
        end
      end
      DONE: tmo_load = coin_valid;
      default: tmo_load = 1'b0;
    endcase
  end

  assign tmo_en = (state == INPUT) || (state == DONE);

  ms_down_counter #(
    .W(TIME_W)
  ) u_tmo (
    .clk      (clk),
    .reset    (reset),
    .load     (tmo_load),
    .load_val (tmo_val),
    .en       (tmo_en),
    .zero     (tmo_zero)
  );

  assign remain_sec = charging ? tmr_cnt : '0;

  // Session FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      credit       <= '0;
      tmr_load     <= 1'b0;
      tmr_load_val <= '0;
      tmr_start    <= 1'b0;
      charging     <= 1'b0;
      refund       <= 1'b0;
      refund_amt   <= '0;
      fault        <= 1'b0;
      ack_cnt      <= '0;
      acked        <= 1'b0;
    end else begin
      refund   <= 1'b0;
      tmr_load <= 1'b0;
      case (state)
        IDLE: begin
          if (coin_valid) begin
            credit <= first.credit;
            state  <= INPUT;
          end
        end
        INPUT: begin
          if (coin_valid) begin
            credit <= add.credit;
            if (add.excess != '0) begin
              refund     <= 1'b1;
              refund_amt <= add.excess;
            end
          end else if (cancel_btn) begin
            refund     <= 1'b1;
            refund_amt <= credit;
            credit     <= '0;
            state      <= IDLE;
          end else if (start_btn) begin
            tmr_load     <= 1'b1;
            tmr_load_val <= TIME_W'(credit) * SPU;
            state        <= LOAD;
          end else if (tmo_zero) begin
            refund     <= 1'b1;
            refund_amt <= credit;
            credit     <= '0;
            state      <= IDLE;
          end
        end
        LOAD: begin
          credit       <= '0;
          tmr_load_val <= '0;
          tmr_start    <= 1'b1;
          charging     <= 1'b1;
          ack_cnt      <= '0;
          acked        <= 1'b0;
          state        <= CHARGING;
        end
        CHARGING: begin
          if (coin_valid) begin
            refund     <= 1'b1;
            refund_amt <= CREDIT_W'(coin_val);
          end
          if (!acked && !tmr_timing &&
              ack_cnt == ACK_LAST) begin
            fault     <= 1'b1;
            tmr_start <= 1'b0;
            charging  <= 1'b0;
            state     <= IDLE;
          end else if (cancel_btn || chg_end) begin
            tmr_start <= 1'b0;
            charging  <= 1'b0;
            state     <= DONE;
          end else if (!acked) begin
            if (tmr_timing) acked <= 1'b1;
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        DONE: begin
          if (coin_valid) begin
            credit <= first.credit;
            state  <= INPUT;
          end else if (tmo_zero) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_charge_session_ctrl.sv
// Bench for charge_session_ctrl with a simple Timer model
// and refund/load scoreboards.
module tb_charge_session_ctrl;
  import charge_session_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        coin_valid = 1'b0;
  logic [3:0]  coin_val = '0;
  logic        start_btn = 1'b0;
  logic        cancel_btn = 1'b0;
  logic        tmr_timing;
  logic [13:0] tmr_cnt;
  logic        tmr_load;
  logic [13:0] tmr_load_val;
  logic        tmr_start;
  logic [4:0]  credit;
  logic [13:0] remain_sec;
  logic        charging;
  logic        refund;
  logic [4:0]  refund_amt;
  logic        fault;

  int n_chk = 0;
  int n_fail = 0;
  logic [4:0]  exp_ref_q[$];
  logic [13:0] exp_load_q[$];
  logic        tm_dead = 1'b0;

  always #5 clk = ~clk;

  charge_session_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .coin_valid   (coin_valid),
    .coin_val     (coin_val),
    .start_btn    (start_btn),
    .cancel_btn   (cancel_btn),
    .tmr_timing   (tmr_timing),
    .tmr_cnt      (tmr_cnt),
    .tmr_load     (tmr_load),
    .tmr_load_val (tmr_load_val),
    .tmr_start    (tmr_start),
    .credit       (credit),
    .remain_sec   (remain_sec),
    .charging     (charging),
    .refund       (refund),
    .refund_amt   (refund_amt),
    .fault        (fault)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  // Timer model: one count per cycle, optional dead mode.
  always @(posedge clk) begin
    if (reset) begin
      tmr_timing <= 1'b0;
      tmr_cnt    <= '0;
    end else if (tmr_load) begin
      tmr_cnt <= tmr_load_val;
    end else if (!tmr_start) begin
      tmr_timing <= 1'b0;
    end else if (!tmr_timing) begin
      if (!tm_dead && tmr_cnt != 0) tmr_timing <= 1'b1;
    end else if (tmr_cnt <= 1) begin
      tmr_cnt    <= '0;
      tmr_timing <= 1'b0;
    end else begin
      tmr_cnt <= tmr_cnt - 1'b1;
    end
  end

  // Scoreboard: every refund/load pulse must match a queued entry.
  always @(negedge clk) begin
    if (refund) begin
      if (exp_ref_q.size() == 0)
        check("refund_unexpected", 1, 0);
      else
        check("refund_amt", refund_amt, exp_ref_q.pop_front());
    end
    if (tmr_load) begin
      if (exp_load_q.size() == 0)
        check("load_unexpected", 1, 0);
      else
        check("load_val", tmr_load_val, exp_load_q.pop_front());
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic coin(input logic [3:0] v);
    coin_valid = 1'b1;
    coin_val   = v;
    cyc();
    coin_valid = 1'b0;
    coin_val   = '0;
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    cyc();
    start_btn = 1'b0;
  endtask

  task automatic press_cancel();
    cancel_btn = 1'b1;
    cyc();
    cancel_btn = 1'b0;
  endtask

  task automatic wait_charging();
    int k;
    k = 0;
    while (!charging && k < 50) begin
      cyc();
      k++;
    end
    check("charging_rise", charging, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tmr_load"}, tmr_load, 0);
    check({tag, "_load_val"}, tmr_load_val, 0);
    check({tag, "_tmr_start"}, tmr_start, 0);
    check({tag, "_credit"}, credit, 0);
    check({tag, "_remain"}, remain_sec, 0);
    check({tag, "_charging"}, charging, 0);
    check({tag, "_refund"}, refund, 0);
    check({tag, "_fault"}, fault, 0);
    check({tag, "_state"}, dut.state, IDLE);
  endtask

  initial begin
    int k;
    cyc(3);
    reset = 1'b0;
    cyc();
    check_zero("rst");

    // Normal session: 5 units -> 300 s, then DONE hold.
    coin(4'd5);
    check("s1_credit", credit, 5);
    exp_load_q.push_back(14'd300);
    press_start();
    check("s1_load_pulse", tmr_load, 1);
    wait_charging();
    check("s1_tmr_start", tmr_start, 1);
    check("s1_credit_clr", credit, 0);
    cyc(10);
    check("s1_remain", remain_sec, tmr_cnt);
    k = 0;
    while (charging && k < 400) begin
      cyc();
      k++;
    end
    check("s1_charge_end", charging, 0);
    check("s1_start_low", tmr_start, 0);
    check("s1_done", dut.state, DONE);
    k = 0;
    while (dut.state != IDLE && k < 3000) begin
      cyc();
      k++;
    end
    check("s1_hold_cycles", k, 2000);

    // Saturation: 10+10+5 -> 20 with 5 refunded.
    coin(4'd10);
    coin(4'd10);
    check("s2_credit20a", credit, 20);
    exp_ref_q.push_back(5'd5);
    coin(4'd5);
    check("s2_refund_now", refund, 1);
    check("s2_credit_sat", credit, 20);
    cyc();
    check("s2_refund_one", refund, 0);
    exp_ref_q.push_back(5'd20);
    press_cancel();
    check("s2_credit_clr", credit, 0);

    // Idle timeout auto-refund.
    coin(4'd3);
    exp_ref_q.push_back(5'd3);
    k = 0;
    while (!refund && k < 10100) begin
      cyc();
      k++;
    end
    check("s3_timeout_cycles", k, 10000);
    check("s3_credit", credit, 0);
    check("s3_state", dut.state, IDLE);

    // Coin and cancel together: coin wins.
    coin_valid = 1'b1;
    coin_val   = 4'd2;
    cancel_btn = 1'b1;
    cyc();
    coin_valid = 1'b0;
    cancel_btn = 1'b0;
    check("s4_credit", credit, 2);
    check("s4_state", dut.state, INPUT);
    coin_valid = 1'b1;
    coin_val   = 4'd1;
    cancel_btn = 1'b1;
    cyc();
    coin_valid = 1'b0;
    cancel_btn = 1'b0;
    check("s4_credit3", credit, 3);
    exp_ref_q.push_back(5'd3);
    press_cancel();
    check("s4_state_idle", dut.state, IDLE);

    // Coin during charge, then cancel mid-charge.
    coin(4'd8);
    exp_load_q.push_back(14'd480);
    press_start();
    wait_charging();
    cyc(5);
    exp_ref_q.push_back(5'd4);
    coin(4'd4);
    check("s5_refund", refund, 1);
    check("s5_state", dut.state, CHARGING);
    check("s5_remain", remain_sec, tmr_cnt);
    check("s5_remain_nz", remain_sec != 0, 1);
    press_cancel();
    check("s5_start_low", tmr_start, 0);
    check("s5_done", dut.state, DONE);
    cyc(3);
    coin(4'd1);
    check("s5_done_coin", dut.state, INPUT);
    check("s5_credit", credit, 1);
    exp_ref_q.push_back(5'd1);
    press_cancel();

    // Timer never acknowledges.
    tm_dead = 1'b1;
    coin(4'd5);
    exp_load_q.push_back(14'd300);
    press_start();
    wait_charging();
    k = 0;
    while (!fault && k < 20) begin
      cyc();
      k++;
    end
    check("s6_fault_cycles", k, 4);
    check("s6_state", dut.state, IDLE);
    check("s6_start_low", tmr_start, 0);
    coin(4'd2);
    check("s6_fault_sticky", fault, 1);
    exp_ref_q.push_back(5'd2);
    press_cancel();
    tm_dead = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("s6_fault_clr", fault, 0);

    // Reset in the middle of a charge.
    coin(4'd6);
    exp_load_q.push_back(14'd360);
    press_start();
    wait_charging();
    cyc(8);
    reset = 1'b1;
    cyc();
    check_zero("s7");
    reset = 1'b0;
    cyc(3);

    check("ref_q_empty", exp_ref_q.size(), 0);
    check("load_q_empty", exp_load_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
